apb_uart_word_serializer: RTL and testbench

- Parametrised successor to the APB-slave-to-UART byte bridge.
- Accepts whole APB write words (data + address) through a valid/ready handshake and buffers them in a DEPTH-word FIFO.
- Serialises each word into 8-bit beats for the UART transmitter, with an optional address header and selectable byte order.
- Pulses a per-word completion strobe, used as pready_slave, once the last byte of a word is acknowledged.

---
 rtl/apb_uart_word_serializer.sv | 177 +++++++++++++++++
 tb/tb_apb_uart_word_serializer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_word_serializer.sv
// Buffers APB write words (address + data) in a small FIFO and serialises each
// one into UART byte beats, with an optional address header and a per-word done strobe.
module apb_uart_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit SEND_ADDR  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic [ADDR_WIDTH-1:0]        addr_in,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [ADDR_WIDTH-1:0]        addr_out,
  output logic                         word_done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int NBYTES  = DATA_WIDTH / 8;
  localparam int ABYTES  = ADDR_WIDTH / 8;
  localparam int HBYTES  = SEND_ADDR ? ABYTES : 0;
  localparam int TOT     = NBYTES + HBYTES;
  localparam int IDX_W   = $clog2(TOT + 1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   tx_valid_q;
  logic [7:0]             tx_data_q;
  logic                   word_done_q;

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [DATA_WIDTH-1:0]  head_data;

  // A full FIFO refuses the offer even if the head is popped in the same cycle.
  assign full     = (cnt_q == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state_q == S_LOAD);

  assign {head_addr, head_data} = mem_q[rd_ptr_q];

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {addr_in, data_in};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat selection: header bytes (if any) first, then data bytes
  // ---------------------------------------------------------------------------
  logic [7:0] beat;

  always_comb begin
    int k;
    beat = '0;
    k    = int'(idx_q);
    if (k < HBYTES) begin
      beat = 8'(addr_q >> (8 * (MSB_FIRST ? (ABYTES - 1 - k) : k)));
    end else begin
      k    = k - HBYTES;
      beat = 8'(data_q >> (8 * (MSB_FIRST ? (NBYTES - 1 - k) : k)));
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      tx_valid_q  <= 1'b0;
      word_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cnt_q != '0) state_q <= S_LOAD;
        end
        S_LOAD: begin
          data_q  <= head_data;
          addr_q  <= head_addr;
          idx_q   <= '0;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= beat;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // tx_done is only meaningful here; pulses in other states are dropped.
          if (tx_done) begin
            if (idx_q == LAST_IDX) begin
              word_done_q <= 1'b1;
              idx_q       <= '0;
              state_q     <= S_IDLE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_SEND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign addr_out   = addr_q;
  assign word_done  = word_done_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_apb_uart_word_serializer.sv
// Scoreboard bench for two serializer configurations: defaults, and
// LSB-first with a 16-bit address header.
module tb_apb_uart_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid   [2];
  logic [31:0] data_in    [2];
  logic [31:0] addr_in    [2];
  logic        in_ready   [2];
  logic        tx_valid   [2];
  logic [7:0]  tx_data    [2];
  logic        word_done  [2];
  logic [2:0]  fifo_count [2];
  logic [31:0] addr_out0;
  logic [15:0] addr_out1;

  logic        stall     [2];
  logic        spur      [2];
  logic        uart_done [2];
  logic        rnd_busy  [2];
  logic        rnd_en;

  int pend        [2];
  int bytes_seen  [2];
  int words_seen  [2];
  int last_tv_cyc [2];
  int cyc = 0;

  logic [7:0]  exp_b [2][$];
  logic [31:0] exp_a [2][$];

  int n_checks = 0;
  int n_pass   = 0;

  apb_uart_word_serializer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b1), .SEND_ADDR(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in[0]), .addr_in(addr_in[0]),
    .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_busy(stall[0] | (rnd_en & rnd_busy[0])),
    .tx_done(uart_done[0] | spur[0]),
    .addr_out(addr_out0), .word_done(word_done[0]), .fifo_count(fifo_count[0])
  );

  apb_uart_word_serializer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(4), .MSB_FIRST(1'b0), .SEND_ADDR(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in[1]), .addr_in(addr_in[1][15:0]),
    .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_busy(stall[1] | (rnd_en & rnd_busy[1])),
    .tx_done(uart_done[1] | spur[1]),
    .addr_out(addr_out1), .word_done(word_done[1]), .fifo_count(fifo_count[1])
  );

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] addr_out_of(int g);
    return (g == 0) ? addr_out0 : {16'h0, addr_out1};
  endfunction

  // Reference model: a word becomes a list of bytes; the field is chopped
  // LSB-first and the list is reversed for MSB-first configurations.
  function automatic void sb_push(int g, logic [31:0] a, logic [31:0] d);
    logic [7:0] hdr[$];
    logic [7:0] dat[$];
    int abytes    = (g == 0) ? 4 : 2;
    bit msb       = (g == 0);
    bit send_addr = (g == 1);
    for (int i = 0; i < abytes; i++) begin
      if (msb) hdr.push_front(a[8*i +: 8]);
      else     hdr.push_back(a[8*i +: 8]);
    end
    for (int i = 0; i < 4; i++) begin
      if (msb) dat.push_front(d[8*i +: 8]);
      else     dat.push_back(d[8*i +: 8]);
    end
    if (send_addr) foreach (hdr[i]) exp_b[g].push_back(hdr[i]);
    foreach (dat[i]) exp_b[g].push_back(dat[i]);
    exp_a[g].push_back((g == 0) ? a : {16'h0, a[15:0]});
  endfunction

  function automatic void flush();
    for (int g = 0; g < 2; g++) begin
      exp_b[g].delete();
      exp_a[g].delete();
    end
  endfunction

  // Ideal UART (tx_done two cycles after tx_valid), random busy source, and monitor.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      logic [7:0]  eb;
      logic [31:0] ea;
      rnd_busy[g]  = ($urandom_range(0, 3) == 0);
      uart_done[g] = 1'b0;
      if (rst) begin
        pend[g] = 0;
      end else begin
        if (pend[g] > 0) begin
          pend[g]--;
          if (pend[g] == 0) uart_done[g] = 1'b1;
        end
        if (tx_valid[g]) begin
          pend[g] = 2;
          check($sformatf("dut%0d byte expected", g), 32'(exp_b[g].size() != 0), 32'd1);
          if (exp_b[g].size() != 0) begin
            eb = exp_b[g].pop_front();
            check($sformatf("dut%0d tx_data", g), 32'(tx_data[g]), 32'(eb));
          end
          bytes_seen[g]++;
          last_tv_cyc[g] = cyc;
        end
        if (word_done[g]) begin
          check($sformatf("dut%0d word_done expected", g), 32'(exp_a[g].size() != 0), 32'd1);
          if (exp_a[g].size() != 0) begin
            ea = exp_a[g].pop_front();
            check($sformatf("dut%0d addr_out", g), addr_out_of(g), ea);
          end
          words_seen[g]++;
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic offer(int g, logic [31:0] a, logic [31:0] d, output bit acc);
    in_valid[g] = 1'b1;
    addr_in[g]  = a;
    data_in[g]  = d;
    acc = in_ready[g];
    if (acc) sb_push(g, a, d);
    idle(1);
  endtask

  task automatic push_word(int g, logic [31:0] a, logic [31:0] d);
    bit acc = 1'b0;
    for (int i = 0; i < 500 && !acc; i++) offer(g, a, d, acc);
    in_valid[g] = 1'b0;
    check($sformatf("dut%0d push accepted", g), 32'(acc), 32'd1);
  endtask

  task automatic wait_bytes(int g, int n, int budget);
    for (int i = 0; i < budget && bytes_seen[g] < n; i++) idle(1);
    check($sformatf("dut%0d bytes reached", g), bytes_seen[g], n);
  endtask

  task automatic wait_words(int g, int n, int budget);
    for (int i = 0; i < budget && words_seen[g] < n; i++) idle(1);
    check($sformatf("dut%0d words reached", g), words_seen[g], n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int  t0, b, w;
    bit  acc [6];
    rst    = 1'b1;
    rnd_en = 1'b0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0; data_in[g] = '0; addr_in[g] = '0;
      stall[g] = 1'b0; spur[g] = 1'b0;
      pend[g] = 0; bytes_seen[g] = 0; words_seen[g] = 0; last_tv_cyc[g] = 0;
    end
    idle(3);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("dut%0d reset tx_valid", g), 32'(tx_valid[g]), 32'd0);
      check($sformatf("dut%0d reset tx_data", g), 32'(tx_data[g]), 32'd0);
      check($sformatf("dut%0d reset addr_out", g), addr_out_of(g), 32'd0);
      check($sformatf("dut%0d reset word_done", g), 32'(word_done[g]), 32'd0);
      check($sformatf("dut%0d reset fifo_count", g), 32'(fifo_count[g]), 32'd0);
      check($sformatf("dut%0d reset in_ready", g), 32'(in_ready[g]), 32'd1);
    end
    rst = 1'b0;
    idle(2);

    // Default configuration: MSB-first data only, first-byte latency.
    t0 = cyc; b = bytes_seen[0]; w = words_seen[0];
    push_word(0, 32'h10, 32'hA1B2C3D4);
    wait_bytes(0, b + 1, 50);
    check("dut0 first byte latency", last_tv_cyc[0] - (t0 + 1), 3);
    wait_words(0, w + 1, 100);
    check("dut0 beats per word", bytes_seen[0] - b, 4);
    check("dut0 addr_out held", addr_out0, 32'h10);
    idle(5);

    // LSB-first with 16-bit address header.
    b = bytes_seen[1]; w = words_seen[1];
    push_word(1, 32'hBEEF, 32'h11223344);
    wait_words(1, w + 1, 200);
    check("dut1 beats per word", bytes_seen[1] - b, 6);
    check("dut1 addr_out held", 32'(addr_out1), 32'hBEEF);
    idle(5);

    // Stalled UART: fill the FIFO, refuse the sixth word, ignore a stray tx_done.
    stall[0] = 1'b1;
    b = bytes_seen[0]; w = words_seen[0];
    for (int i = 0; i < 6; i++)
      offer(0, 32'h100 + 32'(4 * i), 32'h01020304 + 32'(i) * 32'h11111111, acc[i]);
    for (int i = 0; i < 6; i++)
      check($sformatf("stall offer %0d accepted", i), 32'(acc[i]), 32'(i < 5));
    check("full fifo_count", 32'(fifo_count[0]), 32'd4);
    check("full in_ready", 32'(in_ready[0]), 32'd0);
    idle(3);
    check("full fifo_count held", 32'(fifo_count[0]), 32'd4);
    in_valid[0] = 1'b0;
    spur[0] = 1'b1;
    idle(1);
    spur[0] = 1'b0;
    idle(2);
    check("no tx_valid while busy", bytes_seen[0] - b, 0);
    stall[0] = 1'b0;
    wait_words(0, w + 5, 500);
    idle(40);
    check("refused word never sent", words_seen[0] - w, 5);
    check("dut0 scoreboard drained", 32'(exp_b[0].size()), 32'd0);

    // Reset during the second byte with two words still queued.
    b = bytes_seen[0];
    for (int i = 0; i < 3; i++) offer(0, 32'h200 + 32'(i), 32'h55AA0000 + 32'(i), acc[i]);
    in_valid[0] = 1'b0;
    wait_bytes(0, b + 2, 100);
    rst = 1'b1;
    flush();
    idle(1);
    check("midrst tx_valid", 32'(tx_valid[0]), 32'd0);
    check("midrst tx_data", 32'(tx_data[0]), 32'd0);
    check("midrst addr_out", addr_out0, 32'd0);
    check("midrst word_done", 32'(word_done[0]), 32'd0);
    check("midrst fifo_count", 32'(fifo_count[0]), 32'd0);
    idle(1);
    rst = 1'b0;
    w = words_seen[0]; b = bytes_seen[0];
    idle(30);
    check("no word_done after reset", words_seen[0] - w, 0);
    check("no bytes after reset", bytes_seen[0] - b, 0);
    check("in_ready after reset", 32'(in_ready[0]), 32'd1);
    push_word(0, 32'h44, 32'hCAFEF00D);
    wait_words(0, w + 1, 100);
    check("post-reset beats per word", bytes_seen[0] - b, 4);

    // Randomised traffic with a randomly busy UART on both configurations.
    rnd_en = 1'b1;
    for (int g = 0; g < 2; g++) begin
      w = words_seen[g];
      for (int n = 0; n < 16; n++) begin
        idle($urandom_range(0, 3));
        push_word(g, $urandom, $urandom);
      end
      wait_words(g, w + 16, 3000);
      idle(20);
      check($sformatf("dut%0d random drained", g), 32'(exp_b[g].size()), 32'd0);
    end
    rnd_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
